cust1_job_engine: RTL and testbench
===================================

Name: cust1_job_engine

Overview:
- Execution engine behind the CUSTOM1 instruction group (START/POLL/WAIT/GETERR/SETCFG/GETCFG/FENCE). It sits directly downstream of the CPU's custom1 decode.
- Takes one command per handshake, tracks up to JOB_SLOTS jobs in a slot table, and executes them serially with a countdown timer.
- Owns a small config register file and returns one result word per command, tagged with hart/rd for writeback, in the same style as the muldiv completion path.

Parameters:
- XLEN, 32, data width.
- HART_ID_W, 1, hart tag width.
- REG_ADDR_W, 5, rd tag width.
- JOB_SLOTS, 4, job table depth; power of 2.
- JOB_LAT, 16, execution cycles per valid job; must be at least 1.
- CFG_REGS, 8, number of config registers.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine accepts a command this cycle.
- cmd_op  in  3  `CUST1_* funct3 code.
- cmd_a  in  XLEN  rs1 value.
- cmd_b  in  XLEN  rs2 value.
- cmd_hart_id  in  HART_ID_W  issuing hart.
- cmd_rd  in  REG_ADDR_W  destination register.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_data  out  XLEN  result.
- rsp_hart_id  out  HART_ID_W  echoed hart.
- rsp_rd  out  REG_ADDR_W  echoed rd.
- busy  out  1  any job pending or running.

Behaviour:
- Reset (async, rst=1): all outputs 0 except cmd_ready=1. Slot table cleared (status 0), cfg regs 0, next_id=1, both FSMs idle. Reset mid-job discards the job and any pending WAIT/FENCE response.
- Accept: a command is accepted when cmd_valid && cmd_ready. Only one command is outstanding at a time: cmd_ready=0 from acceptance until the cycle after rsp_valid.
- Command FSM:
  - IDLE -> RESP on accept of any non-blocking op.
  - IDLE -> WAIT_JOB on WAIT.
  - IDLE -> WAIT_FENCE on FENCE.
  - RESP: rsp_valid=1 for one cycle, then IDLE. Latency from accept to rsp_valid is 1 cycle.
  - WAIT_JOB and WAIT_FENCE hold until their condition is met, then go to RESP.
- Job IDs: 8-bit counter, 1..255. Wraps 255 -> 1; 0 is never issued. Slot index = id[log2(JOB_SLOTS)-1:0].
- Status codes: 0 unknown, 1 pending/running, 2 done, 3 error.
- START (a=descriptor addr, b=flags):
  - If the target slot has status 1, reject: rsp 0, no allocation.
  - Otherwise store id/addr/flags, set status 1, rsp=id, next_id increments.
  - If a[1:0]!=0, err=1. If b[0]==0, err=2. Errored jobs still queue but complete in 1 exec cycle with status 3.
- Exec FSM:
  - EX_IDLE picks the oldest pending slot in id order and loads the counter with JOB_LAT (1 for errored jobs) -> EX_RUN.
  - EX_RUN decrements the counter; at 0 it writes status 2 or 3 -> EX_IDLE.
  - Back-to-back jobs have one idle cycle between them.
- POLL (a=id): rsp = slot status if the stored id == a[7:0], else 0. Never blocks.
- WAIT (a=id): responds with the status once it is not 1. Unknown id responds 0 immediately. If completion happens in the acceptance cycle, the status written that cycle counts.
- GETERR (a=id): rsp = err code (0 if none or unknown id).
- SETCFG (a=cfg_id, b=value):
  - cfg_id < CFG_REGS: write the register, rsp 0.
  - Otherwise rsp 1, no write.
- GETCFG (a=cfg_id): rsp = register value, or 0 if out of range.
- FENCE: responds 0 once no slot has status 1 and the exec FSM is EX_IDLE.
- Undefined op: rsp 32'hFFFFFFFF, 1-cycle latency.
- busy = any slot has status 1.

Optional Feature:
- Macro: CUST1_IRQ_EN.
- When defined, adds output port `done_irq` (1 bit, reset 0).
  - Set when a job with flags[1]=1 completes (done or error).
  - Cleared in the cycle a POLL, WAIT or GETERR command is accepted.
  - A set and a clear in the same cycle resolves to set.
- When not defined, the port is absent and flags[1] is ignored.

Test Plan:
- After reset: START a=0x00010234 b=1 -> rsp 1. POLL a=1 immediately -> 1. WAIT a=1 -> rsp 2 exactly JOB_LAT+1 cycles after the job starts. GETERR a=1 -> 0.
- SETCFG a=1 b=0x00012034 -> 0; GETCFG a=1 -> 0x00012034. SETCFG a=8 -> 1; GETCFG a=8 -> 0.
- START a=0x1002 b=1 -> id returned; WAIT -> 3; GETERR -> 1. START a=0x1000 b=0 -> GETERR 2.
- Issue 4 STARTs (ids 1-4). A fifth START (id 5 maps to slot 1, still running) -> rsp 0. FENCE -> rsp 0 once all complete; busy=0 in the same cycle as rsp_valid.
- Drive 255 START/WAIT pairs: the ID after 255 is 1. POLL a=0 -> 0. Undefined op -> 0xFFFFFFFF.
- Assert rst during WAIT_JOB: rsp_valid never fires, cmd_ready=1 after reset, POLL of the old id -> 0. With CUST1_IRQ_EN: START b=3 -> done_irq rises at completion and clears on the following POLL.

Source files
------------

// File: rtl/cust1_job_engine.sv
// cust1_job_engine: execution engine for the CUSTOM1 instruction group.
// Accepts one command at a time, keeps a small job slot table, runs jobs
// serially against a countdown timer, and owns a config register file.
// Optional feature macro: CUST1_IRQ_EN adds the done_irq output.
//
// Handshake: a command is taken when cmd_valid && cmd_ready. cmd_ready is
// high only while the command FSM is idle, so it drops on acceptance and
// returns the cycle after the single-cycle rsp_valid pulse.
module cust1_job_engine #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5,
  parameter int JOB_SLOTS  = 4,
  parameter int JOB_LAT    = 16,
  parameter int CFG_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [XLEN-1:0]       cmd_a,
  input  logic [XLEN-1:0]       cmd_b,
  input  logic [HART_ID_W-1:0]  cmd_hart_id,
  input  logic [REG_ADDR_W-1:0] cmd_rd,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_data,
  output logic [HART_ID_W-1:0]  rsp_hart_id,
  output logic [REG_ADDR_W-1:0] rsp_rd,
  output logic                  busy
`ifdef CUST1_IRQ_EN
  ,
  output logic                  done_irq
`endif
);

  localparam int SLOT_W = $clog2(JOB_SLOTS);
  localparam int CNT_W  = $clog2(JOB_LAT + 1);
  localparam int CFG_W  = (CFG_REGS > 1) ? $clog2(CFG_REGS) : 1;

  // funct3 codes of the CUSTOM1 group; 3'd7 is undefined
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_POLL   = 3'd1;
  localparam logic [2:0] OP_WAIT   = 3'd2;
  localparam logic [2:0] OP_GETERR = 3'd3;
  localparam logic [2:0] OP_SETCFG = 3'd4;
  localparam logic [2:0] OP_GETCFG = 3'd5;
  localparam logic [2:0] OP_FENCE  = 3'd6;

  localparam logic [1:0] ST_UNK  = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] CS_IDLE       = 2'd0;
  localparam logic [1:0] CS_RESP       = 2'd1;
  localparam logic [1:0] CS_WAIT_JOB   = 2'd2;
  localparam logic [1:0] CS_WAIT_FENCE = 2'd3;

  localparam logic [0:0] EX_IDLE = 1'b0;
  localparam logic [0:0] EX_RUN  = 1'b1;

  // Slot table. Only the fields that feed a result are kept.
  logic [7:0]            slot_id_q  [JOB_SLOTS];
  logic [1:0]            slot_st_q  [JOB_SLOTS];
  logic [1:0]            slot_err_q [JOB_SLOTS];
  logic [7:0]            next_id_q;
  logic [XLEN-1:0]       cfg_q [CFG_REGS];

  logic [1:0]            cs_q, cs_d;
  logic [SLOT_W-1:0]     wait_slot_q;
  logic [XLEN-1:0]       rsp_data_q, rsp_data_d;
  logic [HART_ID_W-1:0]  rsp_hart_q, rsp_hart_d;
  logic [REG_ADDR_W-1:0] rsp_rd_q, rsp_rd_d;

  logic [0:0]            ex_q;
  logic [CNT_W-1:0]      ex_cnt_q;
  logic [SLOT_W-1:0]     ex_slot_q;

  logic                  accept, start_ok, cfg_we, cfg_in_range, ex_done;
  logic                  pick_valid, any_pending, fence_ok, lk_hit;
  logic [SLOT_W-1:0]     pick_slot, cmd_slot, alloc_slot;
  logic [7:0]            age, best_age;
  logic [1:0]            lk_st, lk_err, done_code, new_err;
  logic [CFG_W-1:0]      cfg_idx;

  assign accept       = cmd_valid && (cs_q == CS_IDLE);
  assign cmd_slot     = cmd_a[SLOT_W-1:0];
  assign alloc_slot   = next_id_q[SLOT_W-1:0];
  assign cfg_in_range = cmd_a < XLEN'(CFG_REGS);
  assign cfg_idx      = cmd_a[CFG_W-1:0];
  // The run phase lasts exactly JOB_LAT cycles; completion lands on the last.
  assign ex_done      = (ex_q == EX_RUN) && (ex_cnt_q == CNT_W'(1));
  assign done_code    = (slot_err_q[ex_slot_q] != 2'd0) ? ST_ERR : ST_DONE;
  assign fence_ok     = !any_pending && (ex_q == EX_IDLE);
  assign new_err      = (cmd_a[1:0] != 2'b00) ? 2'd1 : (!cmd_b[0] ? 2'd2 : 2'd0);

  assign cmd_ready   = (cs_q == CS_IDLE);
  assign rsp_valid   = (cs_q == CS_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_hart_id = rsp_hart_q;
  assign rsp_rd      = rsp_rd_q;
  assign busy        = any_pending;

  // Oldest pending slot: largest distance behind next_id (mod 256 keeps order across the wrap).
  always_comb begin
    pick_valid  = 1'b0;
    pick_slot   = '0;
    best_age    = '0;
    age         = '0;
    any_pending = 1'b0;
    for (int i = 0; i < JOB_SLOTS; i++) begin
      age = next_id_q - slot_id_q[i];
      if (slot_st_q[i] == ST_PEND) begin
        any_pending = 1'b1;
        if (!pick_valid || (age > best_age)) begin
          pick_valid = 1'b1;
          pick_slot  = SLOT_W'(i);
          best_age   = age;
        end
      end
    end
  end

  // Id lookup for POLL/WAIT/GETERR, forwarding a completion landing this cycle.
  always_comb begin
    lk_hit = (slot_id_q[cmd_slot] == cmd_a[7:0]);
    lk_st  = slot_st_q[cmd_slot];
    if (ex_done && (ex_slot_q == cmd_slot)) lk_st = done_code;
    if (!lk_hit) lk_st = ST_UNK;
    lk_err = lk_hit ? slot_err_q[cmd_slot] : 2'd0;
  end

  // Command FSM next state and response word.
  always_comb begin
    cs_d       = cs_q;
    rsp_data_d = rsp_data_q;
    rsp_hart_d = rsp_hart_q;
    rsp_rd_d   = rsp_rd_q;
    start_ok   = 1'b0;
    cfg_we     = 1'b0;
    case (cs_q)
      CS_IDLE: begin
        if (cmd_valid) begin
          rsp_hart_d = cmd_hart_id;
          rsp_rd_d   = cmd_rd;
          cs_d       = CS_RESP;
          case (cmd_op)
            OP_START: begin
              if (slot_st_q[alloc_slot] == ST_PEND) begin
                rsp_data_d = '0;
              end else begin
                rsp_data_d = XLEN'(next_id_q);
                start_ok   = 1'b1;
              end
            end
            OP_POLL:   rsp_data_d = XLEN'(lk_st);
            OP_WAIT: begin
              if (lk_st == ST_PEND) cs_d = CS_WAIT_JOB;
              else rsp_data_d = XLEN'(lk_st);
            end
            OP_GETERR: rsp_data_d = XLEN'(lk_err);
            OP_SETCFG: begin
              cfg_we     = cfg_in_range;
              rsp_data_d = cfg_in_range ? '0 : XLEN'(1);
            end
            OP_GETCFG: rsp_data_d = cfg_in_range ? cfg_q[cfg_idx] : '0;
            OP_FENCE: begin
              if (fence_ok) rsp_data_d = '0;
              else cs_d = CS_WAIT_FENCE;
            end
            default:   rsp_data_d = '1;
          endcase
        end
      end
      CS_WAIT_JOB: begin
        if (slot_st_q[wait_slot_q] != ST_PEND) begin
          rsp_data_d = XLEN'(slot_st_q[wait_slot_q]);
          cs_d       = CS_RESP;
        end
      end
      CS_WAIT_FENCE: begin
        if (fence_ok) begin
          rsp_data_d = '0;
          cs_d       = CS_RESP;
        end
      end
      default: cs_d = CS_IDLE;
    endcase
  end

  // Command FSM state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q        <= CS_IDLE;
      wait_slot_q <= '0;
      rsp_data_q  <= '0;
      rsp_hart_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      cs_q       <= cs_d;
      rsp_data_q <= rsp_data_d;
      rsp_hart_q <= rsp_hart_d;
      rsp_rd_q   <= rsp_rd_d;
      if (accept) wait_slot_q <= cmd_slot;
    end
  end

  // Config register file writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CFG_REGS; i++) cfg_q[i] <= '0;
    end else if (cfg_we) begin
      cfg_q[cfg_idx] <= cmd_b;
    end
  end

  // Slot table and id allocation. START never targets a running slot, so it
  // cannot collide with the completion write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < JOB_SLOTS; i++) begin
        slot_id_q[i]  <= '0;
        slot_st_q[i]  <= ST_UNK;
        slot_err_q[i] <= '0;
      end
      next_id_q <= 8'd1;
    end else begin
      if (start_ok) begin
        slot_id_q[alloc_slot]  <= next_id_q;
        slot_st_q[alloc_slot]  <= ST_PEND;
        slot_err_q[alloc_slot] <= new_err;
        next_id_q <= (next_id_q == 8'd255) ? 8'd1 : next_id_q + 8'd1;
      end
      if (ex_done) slot_st_q[ex_slot_q] <= done_code;
    end
  end

  // Exec FSM: pick oldest pending job, count down, then write its final status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= EX_IDLE;
      ex_cnt_q  <= '0;
      ex_slot_q <= '0;
    end else if (ex_q == EX_IDLE) begin
      if (pick_valid) begin
        ex_q      <= EX_RUN;
        ex_slot_q <= pick_slot;
        ex_cnt_q  <= (slot_err_q[pick_slot] != 2'd0) ? CNT_W'(1) : CNT_W'(JOB_LAT);
      end
    end else if (ex_done) begin
      ex_q     <= EX_IDLE;
      ex_cnt_q <= '0;
    end else begin
      ex_cnt_q <= ex_cnt_q - CNT_W'(1);
    end
  end

`ifdef CUST1_IRQ_EN
  logic slot_irq_q [JOB_SLOTS];
  logic done_irq_q;
  logic irq_clr;

  assign irq_clr  = accept && ((cmd_op == OP_POLL) || (cmd_op == OP_WAIT) || (cmd_op == OP_GETERR));
  assign done_irq = done_irq_q;

  // Per-slot interrupt request flag captured from flags[1] at START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < JOB_SLOTS; i++) slot_irq_q[i] <= 1'b0;
    end else if (start_ok) begin
      slot_irq_q[alloc_slot] <= cmd_b[1];
    end
  end

  // Completion interrupt: set on flagged completion, which wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_irq_q <= 1'b0;
    else if (ex_done && slot_irq_q[ex_slot_q]) done_irq_q <= 1'b1;
    else if (irq_clr) done_irq_q <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cust1_job_engine.sv
// Testbench for cust1_job_engine: table of command vectors plus hand-written
// multi-cycle sequences, with an expected-response queue checked on rsp_valid.
module tb_cust1_job_engine;
  localparam int XLEN = 32;
  localparam int HW   = 1;
  localparam int RW   = 5;
  localparam int L    = 16;
  localparam int EW   = HW + RW + XLEN;

  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_POLL   = 3'd1;
  localparam logic [2:0] OP_WAIT   = 3'd2;
  localparam logic [2:0] OP_GETERR = 3'd3;
  localparam logic [2:0] OP_SETCFG = 3'd4;
  localparam logic [2:0] OP_GETCFG = 3'd5;
  localparam logic [2:0] OP_FENCE  = 3'd6;
  localparam logic [2:0] OP_UNDEF  = 3'd7;

  logic            clk, rst, cmd_valid, cmd_ready, rsp_valid, busy;
  logic [2:0]      cmd_op;
  logic [XLEN-1:0] cmd_a, cmd_b, rsp_data;
  logic [HW-1:0]   cmd_hart_id, rsp_hart_id;
  logic [RW-1:0]   cmd_rd, rsp_rd;
`ifdef CUST1_IRQ_EN
  logic            done_irq;
`endif

  cust1_job_engine dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_hart_id(cmd_hart_id), .cmd_rd(cmd_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hart_id(rsp_hart_id),
    .rsp_rd(rsp_rd), .busy(busy)
`ifdef CUST1_IRQ_EN
    , .done_irq(done_irq)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int    n_chk = 0;
  int    n_fail = 0;
  string cur_name = "none";
  int    acc_cyc, rsp_cyc;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_unexpected_rsp: got rsp data 0x%08h, expected no response", cur_name, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk({cur_name, "_data"}, rsp_data, mon_e[XLEN-1:0]);
        chk({cur_name, "_tag"}, 32'({rsp_hart_id, rsp_rd}), 32'(mon_e[EW-1:XLEN]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'({rsp_hart_id, rsp_rd}), 32'd0);
`ifdef CUST1_IRQ_EN
    chk("rst_done_irq", 32'(done_irq), 32'd0);
`endif
    rst = 1'b0;
  endtask

  // driver: issue one command, queue its expected result, wait for the response
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string name);
    int w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready: cmd_ready is 0, expected 1", name);
      return;
    end
    cur_name    = name;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_hart_id = HW'($urandom_range(0, 1));
    cmd_rd      = RW'($urandom_range(0, 31));
    exp_q.push_back({cmd_hart_id, cmd_rd, exp});
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rsp_valid && w < 2000);
    if (!rsp_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: rsp_valid stayed 0, expected a response", name);
      exp_q.delete();
    end
    rsp_cyc = cyc;
  endtask

  initial begin
    int x1, w;
    logic [31:0] a_v, e_v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_hart_id = '0; cmd_rd = '0;

    tbl[0]  = '{OP_START,  32'h00010234, 32'h1, 32'h1};
    tbl[1]  = '{OP_POLL,   32'h1, 32'h0, 32'h1};
    tbl[2]  = '{OP_WAIT,   32'h1, 32'h0, 32'h2};
    tbl[3]  = '{OP_GETERR, 32'h1, 32'h0, 32'h0};
    tbl[4]  = '{OP_SETCFG, 32'h1, 32'h00012034, 32'h0};
    tbl[5]  = '{OP_GETCFG, 32'h1, 32'h0, 32'h00012034};
    tbl[6]  = '{OP_SETCFG, 32'h8, 32'h55, 32'h1};
    tbl[7]  = '{OP_GETCFG, 32'h8, 32'h0, 32'h0};
    tbl[8]  = '{OP_START,  32'h1002, 32'h1, 32'h2};
    tbl[9]  = '{OP_WAIT,   32'h2, 32'h0, 32'h3};
    tbl[10] = '{OP_GETERR, 32'h2, 32'h0, 32'h1};
    tbl[11] = '{OP_START,  32'h1000, 32'h0, 32'h3};
    tbl[12] = '{OP_WAIT,   32'h3, 32'h0, 32'h3};
    tbl[13] = '{OP_GETERR, 32'h3, 32'h0, 32'h2};
    tbl[14] = '{OP_POLL,   32'h0, 32'h0, 32'h0};
    tbl[15] = '{OP_UNDEF,  32'h1, 32'h1, 32'hFFFFFFFF};
    tbl[16] = '{OP_POLL,   32'h9, 32'h0, 32'h0};
    tbl[17] = '{OP_SETCFG, 32'h7, 32'hDEADBEEF, 32'h0};
    tbl[18] = '{OP_GETCFG, 32'h7, 32'h0, 32'hDEADBEEF};
    tbl[19] = '{OP_GETCFG, 32'h0, 32'h0, 32'h0};
    tbl[20] = '{OP_WAIT,   32'd200, 32'h0, 32'h0};
    tbl[21] = '{OP_FENCE,  32'h0, 32'h0, 32'h0};

    // table-driven vectors
    do_reset();
    for (int i = 0; i < 22; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // WAIT latency and busy; then a WAIT accepted on the completion edge
    do_reset();
    send(OP_START, 32'h0, 32'h1, 32'h1, "lat_start");
    x1 = acc_cyc;
    chk("lat_busy", 32'(busy), 32'd1);
    send(OP_POLL, 32'h1, 32'h0, 32'h1, "lat_poll");
    send(OP_WAIT, 32'h1, 32'h0, 32'h2, "lat_wait");
    chk("lat_wait_cycles", 32'(rsp_cyc - x1), 32'(L + 2));
    send(OP_START, 32'h0, 32'h1, 32'h2, "fwd_start");
    x1 = acc_cyc;
    while (cyc < x1 + L - 1) @(negedge clk);
    send(OP_WAIT, 32'h2, 32'h0, 32'h2, "fwd_wait");
    chk("fwd_wait_accept_cycle", 32'(acc_cyc), 32'(x1 + L + 1));
    chk("fwd_wait_latency", 32'(rsp_cyc - acc_cyc), 32'd0);

    // full slot table, rejected START, FENCE timing
    do_reset();
    send(OP_START, 32'h0, 32'h1, 32'h1, "full_s1");
    x1 = acc_cyc;
    send(OP_START, 32'h0, 32'h1, 32'h2, "full_s2");
    send(OP_START, 32'h0, 32'h1, 32'h3, "full_s3");
    send(OP_START, 32'h0, 32'h1, 32'h4, "full_s4");
    send(OP_START, 32'h0, 32'h1, 32'h0, "full_reject");
    send(OP_FENCE, 32'h0, 32'h0, 32'h0, "full_fence");
    chk("fence_busy", 32'(busy), 32'd0);
    chk("fence_cycles", 32'(rsp_cyc - x1), 32'(4 * L + 5));
    send(OP_START, 32'h0, 32'h1, 32'h5, "full_after");

    // id wrap through 255 START/WAIT pairs, mixing errored jobs
    do_reset();
    for (int i = 1; i <= 255; i++) begin
      a_v = (i % 3 == 0) ? 32'h2 : 32'h0;
      e_v = (i % 3 == 0) ? 32'h3 : 32'h2;
      send(OP_START, a_v, 32'h1, 32'(i), "wrap_start");
      send(OP_WAIT, 32'(i), 32'h0, e_v, "wrap_wait");
    end
    send(OP_GETERR, 32'd255, 32'h0, 32'h1, "wrap_geterr255");
    send(OP_START, 32'h0, 32'h1, 32'h1, "wrap_id1");
    send(OP_POLL, 32'h1, 32'h0, 32'h1, "wrap_poll1");
    send(OP_POLL, 32'h0, 32'h0, 32'h0, "wrap_poll0");

    // reset while a WAIT is outstanding
    do_reset();
    send(OP_START, 32'h0, 32'h1, 32'h1, "rstw_start");
    @(negedge clk);
    cur_name = "rstw_wait";
    cmd_valid = 1'b1; cmd_op = OP_WAIT; cmd_a = 32'h1; cmd_b = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw_ready_while_waiting", 32'(cmd_ready), 32'd0);
    do_reset();
    repeat (L + 6) @(negedge clk);
    chk("rstw_ready_after", 32'(cmd_ready), 32'd1);
    chk("rstw_busy_after", 32'(busy), 32'd0);
    send(OP_POLL, 32'h1, 32'h0, 32'h0, "rstw_poll_old");

`ifdef CUST1_IRQ_EN
    do_reset();
    send(OP_START, 32'h0, 32'h3, 32'h1, "irq_start");
    chk("irq_low_running", 32'(done_irq), 32'd0);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("irq_busy_fell", 32'(busy), 32'd0);
    chk("irq_set", 32'(done_irq), 32'd1);
    send(OP_POLL, 32'h1, 32'h0, 32'h2, "irq_poll");
    chk("irq_cleared", 32'(done_irq), 32'd0);
    send(OP_START, 32'h0, 32'h1, 32'h2, "irq_noflag_start");
    send(OP_WAIT, 32'h2, 32'h0, 32'h2, "irq_noflag_wait");
    chk("irq_noflag", 32'(done_irq), 32'd0);
    send(OP_START, 32'h0, 32'h3, 32'h3, "irq_race_start");
    x1 = acc_cyc;
    while (cyc < x1 + L - 1) @(negedge clk);
    send(OP_POLL, 32'h3, 32'h0, 32'h2, "irq_race_poll");
    chk("irq_set_wins", 32'(done_irq), 32'd1);
    send(OP_GETERR, 32'h3, 32'h0, 32'h0, "irq_geterr");
    chk("irq_geterr_clear", 32'(done_irq), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
